// File: rtl/graph_pkg.sv
// Shared numeric settings for the graph network datapath.
package graph_pkg;
  parameter int PRECISION = 8;
endpackage

// File: rtl/graph_max_pool_if.sv
// Node stream into the max-pool stage and pooled stream out of it.
// master: convolution side / next layer; slave: graph_max_pool.
interface graph_max_pool_if #(
  parameter int ADDR_WIDTH     = 10,
  parameter int OUT_ADDR_WIDTH = 8,
  parameter int PRECISION      = graph_pkg::PRECISION,
  parameter int FEAT_DIM       = 32
);
  logic [ADDR_WIDTH-1:0]                in_addr;
  logic [17:0]                          in_edges;
  logic [FEAT_DIM-1:0][PRECISION-1:0]   in_features;
  logic                                 in_valid;
  logic [1:0]                           in_mem_ptr;
  logic [OUT_ADDR_WIDTH-1:0]            out_addr;
  logic                                 out_active;
  logic [FEAT_DIM-1:0][PRECISION-1:0]   out_features;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [1:0]                           out_mem_ptr;
  logic                                 out_last;

  modport master (
    output in_addr, in_edges, in_features, in_valid, in_mem_ptr, out_ready,
    input  out_addr, out_active, out_features, out_valid, out_mem_ptr, out_last
  );
  modport slave (
    input  in_addr, in_edges, in_features, in_valid, in_mem_ptr, out_ready,
    output out_addr, out_active, out_features, out_valid, out_mem_ptr, out_last
  );
endinterface

// File: rtl/graph_max_pool.sv
// POOLxPOOL max-pooling of one graph frame, streamed out under valid/ready at frame end.
// Optional: define POOL_SKIP_EMPTY_EN to emit only cells that saw an active node.
module graph_max_pool #(
  parameter int GRAPH_SIZE     = 32,
  parameter int POOL           = 2,
  parameter int PRECISION      = graph_pkg::PRECISION,
  parameter int FEAT_DIM       = 32,
  parameter int ZERO_POINT     = 120,
  parameter int ADDR_WIDTH     = $clog2(GRAPH_SIZE*GRAPH_SIZE),
  parameter int OUT_SIZE       = GRAPH_SIZE/POOL,
  parameter int OUT_ADDR_WIDTH = $clog2(OUT_SIZE*OUT_SIZE)
) (
  input  logic              clk,
  input  logic              reset,
  graph_max_pool_if.slave   bus,
  output logic              overflow
);
  localparam int CELLS     = OUT_SIZE*OUT_SIZE;
  localparam int LAST_NODE = GRAPH_SIZE*GRAPH_SIZE-1;
  localparam logic [PRECISION-1:0] ZP = PRECISION'(ZERO_POINT);

  typedef logic [FEAT_DIM-1:0][PRECISION-1:0] feat_t;
  typedef enum logic [0:0] {ACCUM = 1'b0, FLUSH = 1'b1} state_t;

  function automatic feat_t zp_vec();
    feat_t v;
    for (int i = 0; i < FEAT_DIM; i++) v[i] = ZP;
    return v;
  endfunction

  function automatic feat_t feat_max(feat_t a, feat_t b);
    feat_t v;
    for (int i = 0; i < FEAT_DIM; i++) v[i] = (a[i] > b[i]) ? a[i] : b[i];
    return v;
  endfunction

  function automatic logic [OUT_ADDR_WIDTH-1:0] pool_index(logic [ADDR_WIDTH-1:0] a);
    int x, y;
    x = int'(a) % GRAPH_SIZE;
    y = int'(a) / GRAPH_SIZE;
    return OUT_ADDR_WIDTH'((y/POOL)*OUT_SIZE + x/POOL);
  endfunction

  state_t                    state_r, state_s;
  feat_t                     feat_mem_r [CELLS];
  logic [CELLS-1:0]          act_mem_r;
  logic [CELLS-1:0]          valid_r;
  logic                      pend_r, pend_act_r, pend_last_r;
  logic [OUT_ADDR_WIDTH-1:0] pend_cell_r;
  feat_t                     pend_feat_r;
  logic                      frame_started_r;
  logic [1:0]                frame_ptr_r;
  logic [OUT_ADDR_WIDTH-1:0] flush_idx_r;
  logic                      load_done_r;
  logic [OUT_ADDR_WIDTH-1:0] out_addr_r;
  logic                      out_active_r, out_valid_r, out_last_r, overflow_r;
  feat_t                     out_features_r;
  logic [1:0]                out_mem_ptr_r;
`ifdef POOL_SKIP_EMPTY_EN
  logic                      any_active_r;
  logic [OUT_ADDR_WIDTH-1:0] last_active_r;
`endif

  feat_t acc_cur_s, acc_merged_s, fl_feat_s, beat_feat_s;
  logic  acc_act_s, fl_act_s, beat_act_s, emit_s, last_s, slot_free_s, beat_done_s, step_s;

  // Second half of the read-modify-write plus the flush-side cell read.
  always_comb begin
    acc_cur_s    = valid_r[pend_cell_r] ? feat_mem_r[pend_cell_r] : zp_vec();
    acc_merged_s = feat_max(acc_cur_s, pend_feat_r);
    acc_act_s    = (valid_r[pend_cell_r] & act_mem_r[pend_cell_r]) | pend_act_r;
    fl_feat_s    = valid_r[flush_idx_r] ? feat_mem_r[flush_idx_r] : zp_vec();
    fl_act_s     = valid_r[flush_idx_r] & act_mem_r[flush_idx_r];
    slot_free_s  = !out_valid_r || bus.out_ready;
    beat_done_s  = out_valid_r && bus.out_ready && out_last_r;
  end

  // Which flush cells produce a beat and which beat closes the frame.
  always_comb begin
    emit_s      = 1'b1;
    last_s      = 1'b0;
    beat_feat_s = fl_feat_s;
    beat_act_s  = fl_act_s;
`ifdef POOL_SKIP_EMPTY_EN
    if (any_active_r) begin
      emit_s = fl_act_s;
      last_s = (flush_idx_r == last_active_r);
    end else begin
      // Empty frame still emits one marker beat so the boundary is visible.
      emit_s      = (flush_idx_r == {OUT_ADDR_WIDTH{1'b0}});
      last_s      = 1'b1;
      beat_feat_s = zp_vec();
      beat_act_s  = 1'b0;
    end
`else
    last_s = (flush_idx_r == OUT_ADDR_WIDTH'(CELLS-1));
`endif
    step_s = (state_r == FLUSH) && !load_done_r && (!emit_s || slot_free_s);
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ACCUM: begin
        if (pend_r && pend_last_r) state_s = FLUSH;
        else                       state_s = ACCUM;
      end
      FLUSH: begin
        if (beat_done_s) state_s = ACCUM;
        else             state_s = FLUSH;
      end
      default: state_s = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ACCUM;
    else        state_r <= state_s;
  end

  // Input capture stage and frame bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_r          <= 1'b0;
      pend_act_r      <= 1'b0;
      pend_last_r     <= 1'b0;
      pend_cell_r     <= {OUT_ADDR_WIDTH{1'b0}};
      pend_feat_r     <= zp_vec();
      frame_started_r <= 1'b0;
      frame_ptr_r     <= 2'd0;
      overflow_r      <= 1'b0;
    end else begin
      pend_r <= bus.in_valid && (state_r == ACCUM);
      if (bus.in_valid && state_r == ACCUM) begin
        pend_cell_r <= pool_index(bus.in_addr);
        pend_feat_r <= bus.in_features;
        pend_act_r  <= (bus.in_edges != 18'd0);
        pend_last_r <= (bus.in_addr == ADDR_WIDTH'(LAST_NODE));
        if (!frame_started_r) begin
          frame_started_r <= 1'b1;
          frame_ptr_r     <= bus.in_mem_ptr;
        end
      end
      if (bus.in_valid && state_r == FLUSH) overflow_r <= 1'b1;
      if (state_r == FLUSH && beat_done_s) frame_started_r <= 1'b0;
    end
  end

  // Pooled feature storage; contents are qualified by valid_r.
  always_ff @(posedge clk) begin
    if (pend_r) begin
      feat_mem_r[pend_cell_r] <= acc_merged_s;
      act_mem_r[pend_cell_r]  <= acc_act_s;
    end
  end

  // Cell valid bits: set by accumulation, dropped as the flush walks past.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= {CELLS{1'b0}};
    end else if (state_r == FLUSH && beat_done_s) begin
      valid_r <= {CELLS{1'b0}};
    end else begin
      if (step_s) valid_r[flush_idx_r] <= 1'b0;
      if (pend_r) valid_r[pend_cell_r] <= 1'b1;
    end
  end

`ifdef POOL_SKIP_EMPTY_EN
  // Highest active cell, so out_last can mark the final emitted beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      any_active_r  <= 1'b0;
      last_active_r <= {OUT_ADDR_WIDTH{1'b0}};
    end else if (state_r == FLUSH && beat_done_s) begin
      any_active_r  <= 1'b0;
      last_active_r <= {OUT_ADDR_WIDTH{1'b0}};
    end else if (pend_r && acc_act_s) begin
      any_active_r <= 1'b1;
      if (!any_active_r || pend_cell_r > last_active_r) last_active_r <= pend_cell_r;
    end
  end
`endif

  // Flush walker and registered output beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_idx_r    <= {OUT_ADDR_WIDTH{1'b0}};
      load_done_r    <= 1'b0;
      out_addr_r     <= {OUT_ADDR_WIDTH{1'b0}};
      out_active_r   <= 1'b0;
      out_features_r <= zp_vec();
      out_valid_r    <= 1'b0;
      out_last_r     <= 1'b0;
      out_mem_ptr_r  <= 2'd0;
    end else if (state_r == ACCUM) begin
      flush_idx_r <= {OUT_ADDR_WIDTH{1'b0}};
      load_done_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      if (pend_r && pend_last_r) out_mem_ptr_r <= frame_ptr_r;
    end else begin
      if (step_s) flush_idx_r <= flush_idx_r + OUT_ADDR_WIDTH'(1);
      if (step_s && emit_s) begin
        out_addr_r     <= flush_idx_r;
        out_active_r   <= beat_act_s;
        out_features_r <= beat_feat_s;
        out_valid_r    <= 1'b1;
        out_last_r     <= last_s;
        load_done_r    <= last_s;
      end else if (out_valid_r && bus.out_ready) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end
  end

  assign bus.out_addr     = out_addr_r;
  assign bus.out_active   = out_active_r;
  assign bus.out_features = out_features_r;
  assign bus.out_valid    = out_valid_r;
  assign bus.out_mem_ptr  = out_mem_ptr_r;
  assign bus.out_last     = out_last_r;
  assign overflow         = overflow_r;
endmodule

// File: tb/tb_graph_max_pool.sv
// Scoreboard bench for graph_max_pool: a per-cell max model queues expected beats at frame end.
module tb_graph_max_pool;
  localparam int FD = 32;
  localparam int PR = 8;
  localparam int CELLS = 256;
  localparam logic [PR-1:0] ZP = 8'd120;

  typedef logic [FD-1:0][PR-1:0] feat_t;
  typedef struct {
    logic [7:0] addr;
    logic       act;
    feat_t      feat;
    logic       last;
    logic [1:0] ptr;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic overflow;
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;

  graph_max_pool_if #(.ADDR_WIDTH(10), .OUT_ADDR_WIDTH(8), .PRECISION(PR), .FEAT_DIM(FD)) bus ();
  graph_max_pool dut (.clk(clk), .reset(reset), .bus(bus), .overflow(overflow));

  always #5 clk = ~clk;

  beat_t      exp_q[$];
  logic [PR-1:0] m_feat [CELLS][FD];
  logic       m_act [CELLS];
  logic       m_started;
  logic [1:0] m_ptr;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic feat_t zp_vec();
    feat_t v;
    for (int j = 0; j < FD; j++) v[j] = ZP;
    return v;
  endfunction

  function automatic feat_t node_vec(input logic [7:0] f0);
    feat_t v;
    for (int j = 0; j < FD; j++) v[j] = f0;
    v[FD-1] = f0 ^ 8'h5A;
    return v;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < CELLS; c++) begin
      m_act[c] = 1'b0;
      for (int j = 0; j < FD; j++) m_feat[c][j] = ZP;
    end
    m_started = 1'b0;
    m_ptr = 2'd0;
  endtask

  task automatic model_apply(input int addr, input feat_t f, input logic [17:0] edges, input logic [1:0] ptr);
    int c;
    c = ((addr / 32) / 2) * 16 + (addr % 32) / 2;
    for (int j = 0; j < FD; j++) if (f[j] > m_feat[c][j]) m_feat[c][j] = f[j];
    if (edges != 18'd0) m_act[c] = 1'b1;
    if (!m_started) begin
      m_started = 1'b1;
      m_ptr = ptr;
    end
  endtask

  task automatic push_frame();
    beat_t b;
    int last_act;
    last_act = -1;
    for (int c = 0; c < CELLS; c++) if (m_act[c]) last_act = c;
`ifdef POOL_SKIP_EMPTY_EN
    if (last_act < 0) begin
      b.addr = 8'd0; b.act = 1'b0; b.feat = zp_vec(); b.last = 1'b1; b.ptr = m_ptr;
      exp_q.push_back(b);
    end else begin
      for (int c = 0; c <= last_act; c++) begin
        if (m_act[c]) begin
          b.addr = 8'(c); b.act = 1'b1; b.last = (c == last_act); b.ptr = m_ptr;
          for (int j = 0; j < FD; j++) b.feat[j] = m_feat[c][j];
          exp_q.push_back(b);
        end
      end
    end
`else
    for (int c = 0; c < CELLS; c++) begin
      b.addr = 8'(c); b.act = m_act[c]; b.last = (c == CELLS-1); b.ptr = m_ptr;
      for (int j = 0; j < FD; j++) b.feat[j] = m_feat[c][j];
      exp_q.push_back(b);
    end
`endif
    model_clear();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int addr, input feat_t f, input logic [17:0] edges, input logic [1:0] ptr);
    bus.in_addr = 10'(addr);
    bus.in_features = f;
    bus.in_edges = edges;
    bus.in_mem_ptr = ptr;
    bus.in_valid = 1'b1;
  endtask

  task automatic send_node(input int addr, input logic [7:0] f0, input logic [17:0] edges, input logic [1:0] ptr);
    drive(addr, node_vec(f0), edges, ptr);
    model_apply(addr, node_vec(f0), edges, ptr);
    idle(1);
    bus.in_valid = 1'b0;
    if (addr == 1023) push_frame();
    idle(2);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      idle(1);
      n++;
    end
    check_eq("drain_remaining", 256'(exp_q.size()), 256'd0);
    idle(3);
    check_eq("idle_out_valid", 256'(bus.out_valid), 256'd0);
  endtask

  // Downstream ready pattern: 0 always ready, 1 toggle, other held low.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: bus.out_ready = 1'b1;
      1: bus.out_ready = ~bus.out_ready;
      default: bus.out_ready = 1'b0;
    endcase
  end

  logic       stall_r = 1'b0;
  logic [7:0] hold_addr_r;
  feat_t      hold_feat_r;
  logic       hold_last_r;

  // Output monitor: stalled beats must hold, accepted beats pop the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (!reset) begin
      stall_r <= 1'b0;
    end else begin
      if (stall_r) begin
        check_eq("hold_valid", 256'(bus.out_valid), 256'd1);
        check_eq("hold_addr", 256'(bus.out_addr), 256'(hold_addr_r));
        check_eq("hold_feat", 256'(bus.out_features), 256'(hold_feat_r));
        check_eq("hold_last", 256'(bus.out_last), 256'(hold_last_r));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("extra_beat", 256'(bus.out_addr), 256'hFFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("beat_addr", 256'(bus.out_addr), 256'(e.addr));
          check_eq("beat_active", 256'(bus.out_active), 256'(e.act));
          check_eq("beat_feat", 256'(bus.out_features), 256'(e.feat));
          check_eq("beat_last", 256'(bus.out_last), 256'(e.last));
          check_eq("beat_mem_ptr", 256'(bus.out_mem_ptr), 256'(e.ptr));
        end
      end
      stall_r     <= bus.out_valid && !bus.out_ready;
      hold_addr_r <= bus.out_addr;
      hold_feat_r <= bus.out_features;
      hold_last_r <= bus.out_last;
    end
  end

  task automatic frame_basic(input logic [1:0] ptr);
    send_node(0, 8'd130, 18'h00001, ptr);
    send_node(1, 8'd200, 18'h00200, 2'd0);
    send_node(32, 8'd90, 18'h00010, 2'd1);
    send_node(33, 8'd150, 18'h20000, 2'd3);
    send_node(1023, 8'd120, 18'h00000, 2'd0);
  endtask

  initial begin
    bus.in_addr = 10'd0;
    bus.in_edges = 18'd0;
    bus.in_features = zp_vec();
    bus.in_valid = 1'b0;
    bus.in_mem_ptr = 2'd0;
    bus.out_ready = 1'b1;
    model_clear();
    idle(3);
    reset = 1'b1;
    idle(2);

    // Reset state
    check_eq("rst_out_valid", 256'(bus.out_valid), 256'd0);
    check_eq("rst_out_addr", 256'(bus.out_addr), 256'd0);
    check_eq("rst_out_active", 256'(bus.out_active), 256'd0);
    check_eq("rst_out_last", 256'(bus.out_last), 256'd0);
    check_eq("rst_out_mem_ptr", 256'(bus.out_mem_ptr), 256'd0);
    check_eq("rst_overflow", 256'(overflow), 256'd0);
    check_eq("rst_out_features", 256'(bus.out_features), 256'(zp_vec()));

    // Basic frame, always ready
    ready_mode = 0;
    frame_basic(2'd2);
    wait_drain(3000);

    // Same frame with ready toggling
    ready_mode = 1;
    frame_basic(2'd1);
    wait_drain(3000);

    // Input during flush is dropped and raises the sticky overflow
    ready_mode = 0;
    frame_basic(2'd3);
    idle(10);
    drive(5, node_vec(8'd250), 18'h00003, 2'd2);
    idle(1);
    bus.in_valid = 1'b0;
    idle(1);
    check_eq("overflow_set", 256'(overflow), 256'd1);
    wait_drain(3000);
    send_node(1023, 8'd120, 18'h00000, 2'd0);
    wait_drain(3000);
    check_eq("overflow_sticky", 256'(overflow), 256'd1);

    // Consecutive inputs into the same cell
    drive(0, node_vec(8'd150), 18'h00001, 2'd1);
    model_apply(0, node_vec(8'd150), 18'h00001, 2'd1);
    idle(1);
    drive(1, node_vec(8'd180), 18'h00001, 2'd1);
    model_apply(1, node_vec(8'd180), 18'h00001, 2'd1);
    idle(1);
    bus.in_valid = 1'b0;
    idle(2);
    send_node(1023, 8'd120, 18'h00000, 2'd0);
    wait_drain(3000);

    // Reset in the middle of a stalled flush
    ready_mode = 2;
    send_node(0, 8'd222, 18'h00001, 2'd2);
    send_node(1023, 8'd121, 18'h00001, 2'd2);
    idle(20);
    check_eq("stalled_valid", 256'(bus.out_valid), 256'd1);
    reset = 1'b0;
    #1;
    check_eq("abort_valid", 256'(bus.out_valid), 256'd0);
    check_eq("abort_overflow", 256'(overflow), 256'd0);
    exp_q.delete();
    model_clear();
    idle(2);
    reset = 1'b1;
    ready_mode = 0;
    idle(2);
    check_eq("post_abort_valid", 256'(bus.out_valid), 256'd0);
    send_node(1023, 8'd120, 18'h00000, 2'd1);
    wait_drain(3000);

    // Only first and last nodes active
    send_node(0, 8'd140, 18'h00100, 2'd1);
    send_node(1023, 8'd125, 18'h00004, 2'd3);
    wait_drain(3000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/graph_max_pool.md
Name: graph_max_pool

Overview:
- Downstream of the synchronous graph convolution stage. Consumes its per-node output stream: address, 18-bit edge mask, OUTPUT_DIM quantized features, valid strobe and memory pointer.
- Performs POOLxPOOL spatial max-pooling over the GRAPH_SIZE x GRAPH_SIZE node grid and accumulates one pooled frame.
- At frame end, streams the pooled nodes to the next layer under a valid/ready handshake, then clears its buffer for the next frame.

Parameters:
- GRAPH_SIZE, 32, input grid side in nodes.
- POOL, 2, pooling window side; GRAPH_SIZE must be a multiple of POOL.
- PRECISION, graph_pkg::PRECISION, feature width in bits (unsigned quantized).
- FEAT_DIM, 32, features per node.
- ZERO_POINT, 120, quantized zero; neutral/clear value of every feature.
- ADDR_WIDTH, $clog2(GRAPH_SIZE*GRAPH_SIZE), input node address width.
- OUT_SIZE, GRAPH_SIZE/POOL, pooled grid side.
- OUT_ADDR_WIDTH, $clog2(OUT_SIZE*OUT_SIZE), pooled address width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_addr  in  ADDR_WIDTH  node address, y*GRAPH_SIZE+x.
- in_edges  in  18  edge mask; bits [8:0] current, [17:9] old.
- in_features  in  PRECISION x FEAT_DIM  node features.
- in_valid  in  1  one-cycle strobe, one per node.
- in_mem_ptr  in  2  source memory channel of the frame.
- out_addr  out  OUT_ADDR_WIDTH  pooled node address, py*OUT_SIZE+px.
- out_active  out  1  pooled cell received at least one node with nonzero in_edges.
- out_features  out  PRECISION x FEAT_DIM  pooled max features.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accept.
- out_mem_ptr  out  2  latched in_mem_ptr of the frame being streamed.
- out_last  out  1  high on the final beat of a frame.
- overflow  out  1  sticky error flag.

Behaviour:
- Reset (async assert, reset==0):
  - state=ACCUM; all outputs 0 except out_features={default:ZERO_POINT}.
  - Buffer cleared logically: every valid bit 0. A read of an invalid cell returns ZERO_POINT features and active=0.
- Pooled index: px=x/POOL, py=y/POOL, where x=in_addr%GRAPH_SIZE and y=in_addr/GRAPH_SIZE.
- ACCUM state, read-modify-write, 2 cycles:
  - Cycle t (in_valid=1): read the cell.
  - Cycle t+1: write per-feature unsigned max(stored, in_feature); active |= (in_edges!=0); set the valid bit.
- Inputs arrive at least 2 cycles apart (guaranteed by the convolution throughput of 9*FEAT_DIM cycles per node).
  - in_valid on two consecutive cycles to the same cell: the second update must see the first; forward it, never drop it.
- First in_valid of a frame latches in_mem_ptr.
- Frame end: in_valid with in_addr==GRAPH_SIZE*GRAPH_SIZE-1. Its write completes at t+1; state=FLUSH at t+2.
- FLUSH state:
  - Iterates cell 0..OUT_SIZE*OUT_SIZE-1 and presents each beat.
  - A beat holds stable while out_valid && !out_ready; it advances on out_valid && out_ready.
  - out_last=1 on cell OUT_SIZE*OUT_SIZE-1.
  - Each accepted cell's valid bit is cleared, so the buffer is empty when FLUSH ends.
  - After the last handshake: state=ACCUM and out_valid=0 the next cycle.
- in_valid during FLUSH:
  - Input is discarded; overflow <= 1 (sticky until reset).
  - Flush continues unaffected.
- Feature width rule: comparisons are unsigned PRECISION-bit; no saturation is needed.
- Reset mid-FLUSH: abort immediately; buffer invalidated; no partial frame is emitted afterwards.
- out_features and out_addr are registered; the first beat appears 1 cycle after FLUSH entry.

Optional Feature:
- Macro: POOL_SKIP_EMPTY_EN.
- Defined: FLUSH skips cells with active==0. Skipped cells cost one cycle each and produce no beat. out_last marks the last emitted beat.
  - If no cell is active, a single beat (addr 0, active 0, ZERO_POINT features, out_last=1) is still emitted so the frame boundary is visible.
- Undefined: all OUT_SIZE*OUT_SIZE cells are emitted in order.

Test Plan:
1. Reset low then high, no input → outputs 0, out_features all 120, state ACCUM, no out_valid.
2. GRAPH_SIZE=32, POOL=2: nodes 0, 1, 32, 33 with feature[0]=130, 200, 90, 150 and nonzero edges, then node 1023 (feature[0]=120, edges 0), out_ready=1 → 256 beats; addr 0 has feature[0]=200 and active=1; addr 255 has active=0 and features 120; out_last only on addr 255.
3. Same frame with out_ready toggling 1/0 every cycle → beats hold stable while stalled; exactly 256 accepted, in order, none duplicated.
4. in_valid (addr 5) during FLUSH → overflow=1 and stays 1; flushed data unchanged; next frame's cell 2 does not contain addr 5 data.
5. in_valid to addr 0 then addr 1 on consecutive cycles (feature[0]=150, then 180) → addr 0 pooled feature[0]=180.
6. With POOL_SKIP_EMPTY_EN, only nodes 0 and 1023 active → exactly 2 beats (addr 0 and addr 255), out_last on addr 255; out_mem_ptr equals the in_mem_ptr value driven with node 0.
